pump_pwm_driver: RTL
====================

Name: pump_pwm_driver

Overview:
- Sits directly downstream of the dispenser top level.
- Consumes the four level-type pump enables p0..p3 and produces the physical pump gate drives.
- Applies a PWM soft-start ramp to each pump, then holds full drive.
- Enforces a per-pump maximum on-time safety cutoff, so a stuck enable cannot run a pump dry or flood the glass.

Parameters:
- NUM_PUMPS, 4: number of pump channels.
- PWM_BITS, 8: width of the shared PWM counter and of the duty registers.
- RAMP_INC, 16: duty increment per ramp step.
- RAMP_STEP_CYCLES, 50000: clk cycles between ramp steps.
- MAX_ON_CYCLES, 400000000: maximum clk cycles a channel may spend in RAMP+ON before it faults.

Ports:
- clk  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- pump_req  input  NUM_PUMPS  per-pump run request; bit i connects to p<i>. Level-sensitive.
- pump_drv  output  NUM_PUMPS  gate drive to pump i.
- pump_fault  output  NUM_PUMPS  high while channel i is in FAULT.
- busy  output  1  high when any channel is in RAMP or ON.

Behaviour:
- Interface: one clock, clk. RESET is synchronous and active-high. Everything below is sampled on the clk rising edge.
- Reset:
  - pwm_cnt=0.
  - All channels go to IDLE with duty=0, step_cnt=0, on_cnt=0.
  - pump_drv, pump_fault and busy are all 0 after the reset edge.
  - Reset mid-ramp or mid-ON drops drive on the next edge.
- pwm_cnt:
  - Free-running PWM_BITS counter, increments every cycle.
  - Wraps from 2^PWM_BITS-1 to 0.
- Per-channel FSM (IDLE, RAMP, ON, FAULT):
  - IDLE: duty=0, drive 0. If pump_req[i]=1, go to RAMP with duty=RAMP_INC, step_cnt=0, on_cnt=0.
  - RAMP:
    - step_cnt counts 0..RAMP_STEP_CYCLES-1.
    - At terminal count, if duty+RAMP_INC > 2^PWM_BITS-1, go to ON. Otherwise duty += RAMP_INC.
    - Use a PWM_BITS+1 wide compare; the duty register never wraps.
  - ON: drive held solid 1 (100%).
  - FAULT: drive 0, pump_fault[i]=1. Leave for IDLE only when pump_req[i]=0.
- Drive function: pump_drv[i] = (state==RAMP && duty>pwm_cnt) || state==ON. It is combinational from registers only; there is no input-to-output path.
- Latency: request rising at edge N gives RAMP from N+1; drive may first be high in cycle N+1.
- Request dropped in RAMP or ON: go to IDLE at the next edge, so drive is 0 one cycle after the request falls. A re-request restarts the ramp from RAMP_INC.
- Timeout:
  - on_cnt increments every cycle in RAMP or ON and saturates.
  - When on_cnt reaches MAX_ON_CYCLES-1 with the request still high, go to FAULT at the next edge.
  - Timeout takes priority over a ramp step on the same edge.
  - A request drop on that same edge takes priority over timeout: go to IDLE, no fault.
- busy: OR over channels of (RAMP or ON), registered state only.
- Channels are independent unless the optional feature below is enabled.

Optional Feature:
- Macro: PUMP_INTERLOCK_EN.
- Defined:
  - A channel may leave IDLE only when no channel is in RAMP or ON.
  - Among requesters in the same cycle, the lowest index wins; the others stay IDLE and retry each cycle.
  - A channel in FAULT does not block others.
  - Limits supply inrush to one pump.
- Not defined: all channels run concurrently and independently, per Behaviour.

Decomposition:
- Package pump_pkg holds:
  - the state encoding (IDLE=2'd0, RAMP=2'd1, ON=2'd2, FAULT=2'd3);
  - width helper constants for step_cnt and on_cnt, derived with $clog2.
- Sub-module pump_channel: one FSM, duty register, step_cnt and on_cnt. It takes pwm_cnt and a start-grant input.
- The top instantiates NUM_PUMPS channels in a generate loop. It owns pwm_cnt, the interlock arbiter and busy.

Test Plan (PWM_BITS=4, RAMP_INC=4, RAMP_STEP_CYCLES=16, MAX_ON_CYCLES=200):
- Reset: assert RESET 2 cycles with pump_req=4'hF, then release → pump_drv=0, pump_fault=0, busy=0 during reset; ch0..3 enter RAMP one cycle after release.
- Ramp shape: raise req[0] at cycle 0 → RAMP from cycle 1.
  - Duty is 4, 8, 12 for 16 cycles each, so high-time per 16-cycle PWM window is 4, 8, 12.
  - ON from cycle 49; pump_drv[0] is solid 1.
- Early release: raise req[1], drop it at cycle 20 → pump_drv[1]=0 from cycle 21, busy=0. Re-raise → duty restarts at 4.
- Timeout: hold req[2] → pump_fault[2]=1 and pump_drv[2]=0 at cycle 201. Still 1 at cycle 300 while held. Drop req → fault clears next cycle.
- Simultaneous: req=4'b1010 at once → both ramp in lockstep. With PUMP_INTERLOCK_EN: only ch1 runs; ch3 enters RAMP the cycle after ch1 returns to IDLE.
- Reset mid-ON: assert RESET with ch0 in ON → pump_drv[0]=0 at next edge; after release ch0 re-ramps from duty 4.

Source files
------------

// File: rtl/pump_pkg.sv
// Shared state encoding and counter-width helpers for the pump PWM driver.
package pump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_ON    = 2'd2,
    ST_FAULT = 2'd3
  } pump_state_t;

  // Width that can hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_STEP_CYCLES = 50000;
  localparam int DEF_MAX_ON      = 400000000;
  localparam int DEF_STEP_W      = cnt_width(DEF_STEP_CYCLES);
  localparam int DEF_ON_W        = cnt_width(DEF_MAX_ON);

endpackage

// File: rtl/pump_pwm_driver_channel.sv
// One pump channel: soft-start ramp FSM with duty register, step counter
// and saturating on-time counter feeding a maximum on-time cutoff.
module pump_channel
  import pump_pkg::*;
#(
  parameter int PWM_BITS         = 8,
  parameter int RAMP_INC         = 16,
  parameter int RAMP_STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int MAX_ON_CYCLES    = DEF_MAX_ON
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                i_req,
  input  logic                i_grant,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_drv,
  output logic                o_fault,
  output logic                o_active
);

  localparam int STEP_W = cnt_width(RAMP_STEP_CYCLES);
  localparam int ON_W   = cnt_width(MAX_ON_CYCLES);

  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [ON_W-1:0]     ON_LAST   = ON_W'(MAX_ON_CYCLES - 1);
  localparam logic [PWM_BITS:0]   DUTY_MAX  = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [PWM_BITS:0]   INC_WIDE  = (PWM_BITS + 1)'(RAMP_INC);

  pump_state_t         r_state;
  logic [PWM_BITS-1:0] r_duty;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [ON_W-1:0]     r_on_cnt;
  logic [PWM_BITS:0]   w_duty_next;

  // One extra bit so the overflow test sees the carry instead of a wrapped value.
  assign w_duty_next = {1'b0, r_duty} + INC_WIDE;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_duty     <= '0;
      r_step_cnt <= '0;
      r_on_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req && i_grant) begin
            r_state    <= ST_RAMP;
            r_duty     <= PWM_BITS'(RAMP_INC);
            r_step_cnt <= '0;
            r_on_cnt   <= '0;
          end
        end
        ST_RAMP, ST_ON: begin
          if (r_on_cnt != ON_LAST) r_on_cnt <= r_on_cnt + 1'b1;
          // Request drop beats timeout, timeout beats a ramp step.
          if (!i_req) begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
          end else if (r_on_cnt == ON_LAST) begin
            r_state <= ST_FAULT;
            r_duty  <= '0;
          end else if (r_state == ST_RAMP) begin
            if (r_step_cnt == STEP_LAST) begin
              r_step_cnt <= '0;
              if (w_duty_next > DUTY_MAX) r_state <= ST_ON;
              else                        r_duty  <= w_duty_next[PWM_BITS-1:0];
            end else begin
              r_step_cnt <= r_step_cnt + 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (!i_req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_drv    = ((r_state == ST_RAMP) && (r_duty > i_pwm_cnt)) || (r_state == ST_ON);
  assign o_fault  = (r_state == ST_FAULT);
  assign o_active = (r_state == ST_RAMP) || (r_state == ST_ON);

endmodule

// File: rtl/pump_pwm_driver.sv
// Pump gate driver: shared PWM counter, NUM_PUMPS soft-start channels, busy.
// Optional macro PUMP_INTERLOCK_EN allows only one pump in RAMP/ON at a time.
module pump_pwm_driver
  import pump_pkg::*;
#(
  parameter int NUM_PUMPS        = 4,
  parameter int PWM_BITS         = 8,
  parameter int RAMP_INC         = 16,
  parameter int RAMP_STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int MAX_ON_CYCLES    = DEF_MAX_ON
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic [NUM_PUMPS-1:0] pump_req,
  output logic [NUM_PUMPS-1:0] pump_drv,
  output logic [NUM_PUMPS-1:0] pump_fault,
  output logic                 busy
);

  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic [NUM_PUMPS-1:0] w_active;
  logic [NUM_PUMPS-1:0] w_grant;

  always_ff @(posedge clk) begin
    if (RESET) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

`ifdef PUMP_INTERLOCK_EN
  logic w_taken;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_grant = '0;
    w_taken = |w_active;
    for (int i = 0; i < NUM_PUMPS; i++) begin
      if (!w_taken && pump_req[i] && !pump_fault[i]) begin
        w_grant[i] = 1'b1;
        w_taken    = 1'b1;
      end
    end
  end
`else
  assign w_grant = '1;
`endif

  for (genvar g = 0; g < NUM_PUMPS; g++) begin : g_ch
    pump_channel #(
      .PWM_BITS        (PWM_BITS),
      .RAMP_INC        (RAMP_INC),
      .RAMP_STEP_CYCLES(RAMP_STEP_CYCLES),
      .MAX_ON_CYCLES   (MAX_ON_CYCLES)
    ) u_ch (
      .clk      (clk),
      .RESET    (RESET),
      .i_req    (pump_req[g]),
      .i_grant  (w_grant[g]),
      .i_pwm_cnt(r_pwm_cnt),
      .o_drv    (pump_drv[g]),
      .o_fault  (pump_fault[g]),
      .o_active (w_active[g])
    );
  end

  assign busy = |w_active;

endmodule
